// File: rtl/ttm4_clock_gen.sv
// TTM4 CPU clock-enable and clear sequencer: manual step, two divided rates, full speed.
// Define TTM4_CLKGEN_DEBOUNCE_EN to insert the push-button debouncers.
module ttm4_clock_gen #(
  parameter int DIV_SLOW     = 50_000_000,
  parameter int DIV_FAST     = 5_000_000,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int CLR_CYC      = 4,
  parameter int LED_HOLD     = 5_000_000
) (
  input  logic       CK,
  input  logic       RST,
  input  logic [1:0] MODE,
  input  logic       STEP_BTN,
  input  logic       RESET_BTN,
  output logic       CPU_CKE,
  output logic       CPU_nCLR,
  output logic       TICK_LED
);

  localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int DIV_W   = $clog2(DIV_MAX + 1);
  localparam int CLR_W   = $clog2(CLR_CYC + 1);
  localparam int LED_W   = $clog2(LED_HOLD + 1);

  localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(DIV_SLOW - 1);
  localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(DIV_FAST - 1);
  localparam logic [CLR_W-1:0] CLR_LAST  = CLR_W'(CLR_CYC - 1);
  localparam logic [LED_W-1:0] LED_MAX   = LED_W'(LED_HOLD);

  if (DIV_SLOW < 2 || DIV_FAST < 2 || DEBOUNCE_CYC < 1 || CLR_CYC < 1 || LED_HOLD < 1)
  begin : g_param_check
    $error("ttm4_clock_gen: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_GUARD = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Button vectors: bit 0 = STEP_BTN, bit 1 = RESET_BTN.
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       prev_q, prev_d;
  logic [1:0]       stable;
  logic [1:0]       press;

  state_t           state_q, state_d;
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             cke_q, cke_d;
  logic [LED_W-1:0] led_cnt_q, led_cnt_d;

  logic             run;
  logic             div_mode;
  logic [DIV_W-1:0] div_last;
  logic [DIV_W-1:0] div_cur;
  logic             div_hit;
  logic             tick_src;

`ifdef TTM4_CLKGEN_DEBOUNCE_EN
  localparam int              DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC);

  logic [1:0]      stable_q, stable_d;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];

  // The level is accepted one cycle after the mismatch run reaches the threshold.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (db_cnt_q[i] == DB_LAST) begin
        stable_d[i] = sync2_q[i];
      end else if (sync2_q[i] != stable_q[i]) begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      stable_q    <= 2'b11;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign stable = stable_q;
`else
  assign stable = sync2_q;
`endif

  assign press = prev_q & ~stable;
  assign run   = (state_q == ST_RUN);

  always_comb begin
    sync1_d = {RESET_BTN, STEP_BTN};
    sync2_d = sync1_q;
    prev_d  = stable;
    mode_d  = MODE;
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (press[1]) begin
      state_d   = ST_CLEAR;
      clr_cnt_d = '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_cnt_q == CLR_LAST) begin
            state_d   = ST_GUARD;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + CLR_W'(1);
          end
        end
        ST_GUARD: state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        default:  state_d = ST_CLEAR;
      endcase
    end
  end

  // A mode change restarts the count in the same cycle, so a stale count never ticks.
  always_comb begin
    div_mode  = (MODE == 2'b01) || (MODE == 2'b10);
    div_last  = (MODE == 2'b01) ? SLOW_LAST : FAST_LAST;
    div_cur   = (run && (MODE == mode_q)) ? div_cnt_q : '0;
    div_hit   = div_mode && (div_cur == div_last);
    div_cnt_d = '0;
    if (run && div_mode && !div_hit) begin
      div_cnt_d = div_cur + DIV_W'(1);
    end
  end

  // A reset press wins over any tick in the same cycle.
  always_comb begin
    case (MODE)
      2'b00:   tick_src = press[0];
      2'b11:   tick_src = 1'b1;
      default: tick_src = div_hit;
    endcase
    cke_d = run && !press[1] && tick_src;
    if (cke_q) begin
      led_cnt_d = LED_MAX;
    end else if (led_cnt_q != '0) begin
      led_cnt_d = led_cnt_q - LED_W'(1);
    end else begin
      led_cnt_d = '0;
    end
  end

  always_ff @(posedge CK) begin
    mode_q <= mode_d;
    if (RST) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      prev_q    <= 2'b11;
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      div_cnt_q <= '0;
      cke_q     <= 1'b0;
      led_cnt_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      div_cnt_q <= div_cnt_d;
      cke_q     <= cke_d;
      led_cnt_q <= led_cnt_d;
    end
  end

  assign CPU_CKE  = cke_q;
  assign CPU_nCLR = (state_q != ST_CLEAR);
  assign TICK_LED = (led_cnt_q != '0);

endmodule

// File: tb/tb_ttm4_clock_gen.sv
// Scoreboard bench for ttm4_clock_gen: a cycle-level reference built on sequence age and
// modular divider phase pushes expected outputs; a negedge monitor pops and compares.
module tb_ttm4_clock_gen;

  localparam int DIV_SLOW = 8;
  localparam int DIV_FAST = 4;
  localparam int DEB      = 4;
  localparam int CLR      = 4;
  localparam int LEDH     = 3;

  logic       CK = 1'b0;
  logic       RST;
  logic [1:0] MODE;
  logic       STEP_BTN;
  logic       RESET_BTN;
  logic       CPU_CKE;
  logic       CPU_nCLR;
  logic       TICK_LED;

  always #5 CK = ~CK;

  ttm4_clock_gen #(
    .DIV_SLOW    (DIV_SLOW),
    .DIV_FAST    (DIV_FAST),
    .DEBOUNCE_CYC(DEB),
    .CLR_CYC     (CLR),
    .LED_HOLD    (LEDH)
  ) dut (
    .CK       (CK),
    .RST      (RST),
    .MODE     (MODE),
    .STEP_BTN (STEP_BTN),
    .RESET_BTN(RESET_BTN),
    .CPU_CKE  (CPU_CKE),
    .CPU_nCLR (CPU_nCLR),
    .TICK_LED (TICK_LED)
  );

  typedef struct {
    int cyc;
    bit cke;
    bit nclr;
    bit led;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;

  // Reference state: seq_age counts cycles since the current clear sequence began;
  // divider ticks fall where (cycle - origin) mod N == N-1.
  int         cyc = 1;
  int         seq_age;
  int         origin = 0;
  int         led_m;
  bit         cke_m;
  logic [1:0] mode_prev;
  bit         s1[2], s2[2], stab[2], prv[2];
  int         dbc[2];

  task automatic model_step();
    bit   raw[2];
    bit   s2_old;
    bit   pr_s, pr_r, run, divtick, tick;
    int   n;
    exp_t e;
    raw[0] = STEP_BTN;
    raw[1] = RESET_BTN;
    if (RST) begin
      seq_age = 0;
      cke_m   = 1'b0;
      led_m   = 0;
      for (int i = 0; i < 2; i++) begin
        s1[i] = 1'b1; s2[i] = 1'b1; stab[i] = 1'b1; prv[i] = 1'b1; dbc[i] = 0;
      end
    end else begin
      pr_s = prv[0] && !stab[0];
      pr_r = prv[1] && !stab[1];
      run  = (seq_age > CLR);
      if (seq_age == CLR + 1 || MODE != mode_prev) origin = cyc - 1;
      n       = (MODE == 2'b01) ? DIV_SLOW : DIV_FAST;
      divtick = (MODE == 2'b01 || MODE == 2'b10) && (((cyc - 1 - origin) % n) == n - 1);
      tick    = run && !pr_r &&
                ((MODE == 2'b00) ? pr_s : (MODE == 2'b11) ? 1'b1 : divtick);
      led_m   = cke_m ? LEDH : ((led_m > 0) ? led_m - 1 : 0);
      cke_m   = tick;
      seq_age = pr_r ? 0 : ((seq_age < CLR + 2) ? seq_age + 1 : seq_age);
      for (int i = 0; i < 2; i++) begin
        prv[i] = stab[i];
        s2_old = s2[i];
        s2[i]  = s1[i];
        s1[i]  = raw[i];
`ifdef TTM4_CLKGEN_DEBOUNCE_EN
        if (dbc[i] == DEB) begin
          stab[i] = s2_old;
          dbc[i]  = 0;
        end else if (s2_old != stab[i]) begin
          dbc[i] = dbc[i] + 1;
        end else begin
          dbc[i] = 0;
        end
`else
        stab[i] = s2[i];
`endif
      end
    end
    mode_prev = MODE;
    e.cyc  = cyc;
    e.cke  = cke_m;
    e.nclr = (seq_age >= CLR);
    e.led  = (led_m != 0);
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic cyc_in(input bit r, input logic [1:0] m, input bit s, input bit b);
    @(posedge CK);
    #1;
    RST       = r;
    MODE      = m;
    STEP_BTN  = s;
    RESET_BTN = b;
    model_step();
  endtask

  task automatic chk(input string name, input int c, input logic act, input bit req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, c, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CK);
      if (exp_q.size() == 0) begin
        if (!done) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard_underflow at time %0t: got empty queue, expected entry", $time);
        end
      end else begin
        e = exp_q.pop_front();
        chk("CPU_CKE",  e.cyc, CPU_CKE,  e.cke);
        chk("CPU_nCLR", e.cyc, CPU_nCLR, e.nclr);
        chk("TICK_LED", e.cyc, TICK_LED, e.led);
      end
    end
  end

  initial begin : stimulus
    logic [1:0] rmode;
    bit         rstep;
    bit         rrst;
    int         rb_hold;
    RST = 1'b1; MODE = 2'b01; STEP_BTN = 1'b1; RESET_BTN = 1'b1;
    model_step();
    repeat (2) cyc_in(1, 2'b01, 1, 1);
    // Clear sequence then slow run
    repeat (60) cyc_in(0, 2'b01, 1, 1);
    // Switch slow -> fast mid-count
    repeat (3)  cyc_in(0, 2'b01, 1, 1);
    repeat (25) cyc_in(0, 2'b10, 1, 1);
    // Manual step with a bouncing button
    for (int i = 0; i < 3; i++) cyc_in(0, 2'b00, i[0], 1);
    repeat (10) cyc_in(0, 2'b00, 0, 1);
    repeat (12) cyc_in(0, 2'b00, 1, 1);
    // Step pressed in fast mode must not be queued into manual mode
    repeat (8)  cyc_in(0, 2'b10, 0, 1);
    repeat (10) cyc_in(0, 2'b00, 0, 1);
    repeat (10) cyc_in(0, 2'b00, 1, 1);
    // Reset-button press at full speed
    repeat (10) cyc_in(0, 2'b11, 1, 1);
    repeat (8)  cyc_in(0, 2'b11, 1, 0);
    repeat (25) cyc_in(0, 2'b11, 1, 1);
    // RST mid-run
    cyc_in(1, 2'b11, 1, 1);
    repeat (15) cyc_in(0, 2'b11, 1, 1);
    // Randomized traffic
    rmode   = 2'b01;
    rstep   = 1'b1;
    rb_hold = 0;
    repeat (3000) begin
      if ($urandom_range(39) == 0) rmode = 2'($urandom_range(3));
      if ($urandom_range(5) == 0)  rstep = ~rstep;
      if (rb_hold == 0 && $urandom_range(199) == 0) rb_hold = 7;
      rrst = ($urandom_range(499) == 0);
      cyc_in(rrst, rmode, rstep, (rb_hold == 0));
      if (rb_hold > 0) rb_hold--;
    end
    done = 1'b1;
    repeat (3) @(posedge CK);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
